// File: rtl/tick_pacer_pkg.sv
// Shared definitions for the tick-paced sample stage: FSM encoding and the
// occupancy/pointer width helper used by both the pacer and its FIFO.
package tick_pacer_pkg;

    localparam logic ST_FILL = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    typedef enum logic {
        FILL = ST_FILL,
        RUN  = ST_RUN
    } state_e;

    // One extra bit beyond the address so that a full FIFO (level == DEPTH) is representable.
    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/tick_sample_pacer_sync_fifo.sv
// Single-clock FIFO for the pacer: registered pointers/level, head word read
// combinationally from the read pointer (no write-to-read bypass).
module sync_fifo
    import tick_pacer_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [lvl_w(DEPTH)-1:0]  level,
    output logic                     full,
    output logic                     empty
);

    localparam int LW = lvl_w(DEPTH);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [LW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             push_en, pop_en;

    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;
    assign head    = mem_q[rd_ptr_q[AW-1:0]];
    assign level   = level_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q + LW'(push_en);
        rd_ptr_d = rd_ptr_q + LW'(pop_en);
        level_d  = level_q + LW'(push_en) - LW'(pop_en);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage is data only; reset discards contents by clearing the pointers.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/tick_sample_pacer.sv
// Releases one buffered sample per tick to the DAC interface after a prefill,
// holding the output between ticks and flagging underruns.
module tick_sample_pacer
    import tick_pacer_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter int               DEPTH       = 16,
    parameter int               START_LEVEL = 8,
    parameter logic [WIDTH-1:0] IDLE_VALUE  = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     tick,
    input  logic [WIDTH-1:0]         s_data,
    input  logic                     s_valid,
    output logic                     s_ready,
    output logic [WIDTH-1:0]         dac_data,
    output logic                     dac_strobe,
    output logic                     running,
    output logic                     underrun,
    input  logic                     clr_underrun,
    output logic [lvl_w(DEPTH)-1:0]  level
);

    localparam int LW = lvl_w(DEPTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] dac_data_q, dac_data_d;
    logic             dac_strobe_q, dac_strobe_d;
    logic             running_q, running_d;
    logic             underrun_q, underrun_d;

    logic [WIDTH-1:0] head;
    logic [LW-1:0]    fifo_level;
    logic             full, empty, push, pop;

    assign s_ready = !full;
    assign push    = s_valid && s_ready;
    assign pop     = (state_q == RUN) && tick && !empty;

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (s_data),
        .pop       (pop),
        .head      (head),
        .level     (fifo_level),
        .full      (full),
        .empty     (empty)
    );

    always_comb begin
        state_d      = state_q;
        dac_data_d   = dac_data_q;
        dac_strobe_d = 1'b0;
        running_d    = running_q;
        underrun_d   = underrun_q && !clr_underrun;
        case (state_q)
            FILL: begin
                if (fifo_level >= LW'(START_LEVEL)) begin
                    state_d   = RUN;
                    running_d = 1'b1;
                end
            end
            RUN: begin
                if (tick) begin
                    dac_strobe_d = 1'b1;
                    if (!empty) begin
                        dac_data_d = head;
                    end else begin
                        // Starved: emit idle, flag it, and re-prefill before resuming.
                        dac_data_d = IDLE_VALUE;
                        underrun_d = 1'b1;
                        state_d    = FILL;
                        running_d  = 1'b0;
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= FILL;
            dac_data_q   <= IDLE_VALUE;
            dac_strobe_q <= 1'b0;
            running_q    <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            dac_data_q   <= dac_data_d;
            dac_strobe_q <= dac_strobe_d;
            running_q    <= running_d;
            underrun_q   <= underrun_d;
        end
    end

    assign dac_data   = dac_data_q;
    assign dac_strobe = dac_strobe_q;
    assign running    = running_q;
    assign underrun   = underrun_q;
    assign level      = fifo_level;

endmodule

// File: doc/tick_sample_pacer.md
Name: tick_sample_pacer

Overview:
Sample pacing stage that sits directly downstream of the terminal-count tick generator in the TX datapath. It buffers samples arriving from the upstream source in a small FIFO and releases exactly one sample to the DAC/modulator interface per input tick. It prefills before starting, holds data between ticks, and flags underruns.

Parameters:
WIDTH, 8, sample width in bits
DEPTH, 16, FIFO depth in words; power of two, >= 2
START_LEVEL, 8, fill level (1..DEPTH) required to enter RUN
IDLE_VALUE, 0, WIDTH-bit value driven on dac_data when no sample is available

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
tick  in  1  one-cycle sample-rate pulse (terminal count of the tick generator)
s_data  in  WIDTH  upstream sample
s_valid  in  1  s_data valid
s_ready  out  1  FIFO can accept; transfer when s_valid && s_ready
dac_data  out  WIDTH  current output sample, held between strobes
dac_strobe  out  1  one-cycle pulse: dac_data updated this cycle
running  out  1  high in RUN state
underrun  out  1  sticky underrun flag
clr_underrun  in  1  clears underrun
level  out  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH

Behaviour:
- Reset (async, immediate): pointers=0, level=0, state=FILL, dac_data=IDLE_VALUE, dac_strobe=0, running=0, underrun=0. s_ready=1 once rst deasserts.
- Pointers are $clog2(DEPTH)+1 bits wide and wrap naturally. full = level==DEPTH; empty = level==0. Both are derived from registered state.
- s_ready = !full, combinational from registered state only. It does not depend on s_valid or tick.
- Push when s_valid && s_ready. Pop only when the FSM issues a pop on a non-empty FIFO.
- Push and pop in the same cycle: level unchanged, both pointers advance.
- No bypass: a word pushed in cycle N is poppable from cycle N+1.
- FSM state FILL:
  - tick is ignored: no pop, no strobe, dac_data holds.
  - Goes to RUN on the clock edge where registered level >= START_LEVEL. running=1 from that edge onward.
- FSM state RUN, on tick:
  - Non-empty: pop the head word. dac_data <= head, dac_strobe <= 1. Output latency is exactly 1 clock after the tick cycle.
  - Empty: dac_data <= IDLE_VALUE, dac_strobe <= 1, underrun <= 1, state -> FILL, running <= 0.
- RUN with no tick: dac_strobe=0, dac_data holds.
- underrun is sticky until a cycle with clr_underrun=1. Set has priority over clear in the same cycle.
- tick held high for several cycles: each high cycle is treated as a separate tick. Upstream guarantees single-cycle pulses.
- Reset mid-operation discards all buffered data. There is no partial-state retention.

Decomposition:
- Shared package/include tick_pacer_pkg holds:
  - state encoding localparams ST_FILL=1'b0, ST_RUN=1'b1
  - the level-width function ($clog2(DEPTH)+1) used by top and sub-module
- Sub-module sync_fifo (WIDTH, DEPTH):
  - owns storage, pointers, level, full/empty and the push/pop interface
  - read data is the head word, combinational from the read pointer
- tick_sample_pacer keeps the FSM, output registers and the underrun logic.

Test Plan:
(WIDTH=8, DEPTH=4, START_LEVEL=2, IDLE_VALUE=8'h00)
1. Prefill: push 8'h11, pulse tick, then push 8'h22 -> first tick produces no strobe. running=1 one edge after level=2. Next tick -> following cycle dac_data=8'h11, dac_strobe=1 for exactly 1 cycle.
2. Full/backpressure: push 8'h01..8'h05 with no tick -> s_ready=0 after the 4th accept, level=4, 8'h05 stalls. A tick pops 8'h01 -> s_ready=1, 8'h05 accepted next edge.
3. Simultaneous push+pop at level=3 (RUN): tick and s_valid in the same cycle -> level stays 3, output is the oldest word, the new word is appended at the tail.
4. Underrun: in RUN, drain to level=0, pulse tick -> next cycle dac_data=8'h00, dac_strobe=1, underrun=1, running=0. clr_underrun=1 -> underrun=0. clr_underrun in the same cycle as a new underrun -> underrun stays 1.
5. Async reset mid-run: level=3, dac_data=8'h22, assert rst between clock edges -> dac_data=8'h00, level=0, running=0 immediately. After release, a tick produces no strobe until prefill completes.
6. Tick ignored in FILL after underrun: pulse ticks with level=1 -> no strobe, dac_data stays 8'h00. Push a 2nd word -> RUN resumes.
